prod_accum: RTL

- Downstream consumer of the 4-bit array multiplier stage.
- Accepts a stream of 8-bit products over a valid/ready handshake and sums up to N_TERMS products per frame into a saturating accumulator.
- Presents the frame sum with a valid/ready output handshake, which makes small dot products and multiply-accumulate possible from the combinational multiplier.

---
 rtl/prod_accum.sv | 131 +++++++++++++
 1 files changed

// File: rtl/prod_accum.sv
// prod_accum: sums a frame of up to N_TERMS unsigned 8-bit products into a
// saturating ACC_W-bit accumulator and hands the frame result downstream
// over a valid/ready handshake. Input and output handshakes never overlap:
// while a result waits in DONE, no new product is accepted.
module prod_accum #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_cnt,
  output logic             out_sat
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [7:0]       cnt;
  logic             sat;

  logic             take;
  logic             give;
  logic [ACC_W-1:0] in_ext;
  logic [ACC_W:0]   sum_wide;
  logic             add_ovf;
  logic [ACC_W-1:0] add_res;
  logic [8:0]       cnt_inc;
  logic             first_closes;
  logic             accum_closes;

  // The extra top bit of the widened sum flags overflow; on overflow the
  // accumulator pins at all-ones, so a saturated frame stays saturated.
  assign take         = in_valid && in_ready;
  assign give         = out_valid && out_ready;
  assign in_ext       = ACC_W'(in_p);
  assign sum_wide     = {1'b0, acc} + {1'b0, in_ext};
  assign add_ovf      = sum_wide[ACC_W];
  assign add_res      = add_ovf ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  assign cnt_inc      = {1'b0, cnt} + 9'd1;
  assign first_closes = in_last || (N_TERMS == 1);
  assign accum_closes = in_last || (cnt_inc == 9'(N_TERMS));

  // Frame state machine; every output, including in_ready, is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (take) begin
            acc <= in_ext;
            cnt <= 8'd1;
            sat <= 1'b0;
            if (first_closes) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= in_ext;
              out_cnt   <= 8'd1;
              out_sat   <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end else begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
          end
        end

        ACCUM: begin
          in_ready <= 1'b1;
          if (take) begin
            acc <= add_res;
            cnt <= cnt_inc[7:0];
            sat <= sat | add_ovf;
            if (accum_closes) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= add_res;
              out_cnt   <= cnt_inc[7:0];
              out_sat   <= sat | add_ovf;
            end
          end
        end

        DONE: begin
          if (give) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
          end else begin
            in_ready <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
